// File: rtl/acondicionador_botones_rtc.sv
// ---------------------------------------------------------------------------
// acondicionador_botones_rtc
// Conditions four raw, asynchronous push-buttons into clean one-cycle
// enables for the RTC configuration counters. Each button gets a 2-FF
// synchronizer and a counter-based debouncer. A shared FSM gives ownership
// to one button at a time (priority UP > DOWN > RIGHT > LEFT). It emits one
// pulse per press and, for buttons enabled in REP_EN, auto-repeats while
// the button is held.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   btn_up      raw button inputs, active high, asynchronous to clk
//   btn_down
//   btn_right
//   btn_left
//   enUP        one-cycle enables, registered, at most one high per cycle
//   enDOWN
//   enRIGHT
//   enLEFT
//   btn_estado  debounced levels {LEFT,RIGHT,DOWN,UP}
// ---------------------------------------------------------------------------
module acondicionador_botones_rtc #(
   parameter int unsigned DEB_CNT   = 1_000_000,
   parameter int unsigned REP_DELAY = 50_000_000,
   parameter int unsigned REP_RATE  = 10_000_000,
   parameter logic [3:0]  REP_EN    = 4'b0011,
   parameter int unsigned CNT_W     = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_right,
   input  logic       btn_left,
   output logic       enUP,
   output logic       enDOWN,
   output logic       enRIGHT,
   output logic       enLEFT,
   output logic [3:0] btn_estado
);

   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST       = CNT_W'(DEB_CNT - 1);
   // The repeat counter starts one cycle after the pulse (in ESPERA), so the
   // repeat pulse is issued on the edge where the count reaches REP_DELAY-1.
   // That places it exactly REP_DELAY cycles after the first pulse.
   localparam logic [CNT_W-1:0] REP_DELAY_PRE  = CNT_W'(REP_DELAY - 2);
   localparam logic [CNT_W-1:0] REP_DELAY_LAST = CNT_W'(REP_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_RATE_LAST  = CNT_W'(REP_RATE - 1);

   typedef enum logic [2:0] {
      IDLE,
      PULSO,
      ESPERA,
      REPITE,
      SOLTAR
   } state_t;

   logic [3:0]       w_raw;
   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [CNT_W-1:0] r_debCnt [4];
   logic [3:0]       r_estado;

   state_t           r_state;
   logic [1:0]       r_owner;
   logic [CNT_W-1:0] r_repCnt;
   logic [3:0]       r_en;

   logic [1:0]       w_prioIdx;
   logic [3:0]       w_ownerMask;
   logic             w_ownerHeld;

   assign w_raw = {btn_left, btn_right, btn_down, btn_up};

   // Two-stage synchronizer bringing the asynchronous buttons into the clk domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debouncers: a counter runs only while the synced input disagrees with the
   // debounced level. Any agreement restarts it, so only a disagreement that
   // lasts DEB_CNT cycles changes the level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_debCnt[i] <= '0;
         end
         r_estado <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_estado[i]) begin
               r_debCnt[i] <= '0;
            end else if (r_debCnt[i] == DEB_LAST) begin
               r_estado[i] <= r_sync2[i];
               r_debCnt[i] <= '0;
            end else begin
               r_debCnt[i] <= r_debCnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Fixed-priority pick of the button that claims ownership when leaving IDLE.
   always_comb begin
      w_prioIdx = 2'd3;
      if (r_estado[0]) begin
         w_prioIdx = 2'd0;
      end else if (r_estado[1]) begin
         w_prioIdx = 2'd1;
      end else if (r_estado[2]) begin
         w_prioIdx = 2'd2;
      end
   end

   assign w_ownerMask = 4'b0001 << r_owner;
   assign w_ownerHeld = r_estado[r_owner];

   // Arbitration / pulse FSM. The enables are registered and are set only on
   // the edge that issues a pulse, then cleared by default on the next edge.
   // Only the owner's level is looked at once it is latched, so other presses
   // are ignored until every button is released and the FSM is back in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_owner  <= '0;
         r_repCnt <= '0;
         r_en     <= '0;
      end else begin
         r_en <= '0;
         case (r_state)
            IDLE: begin
               if (|r_estado) begin
                  r_owner <= w_prioIdx;
                  r_en    <= 4'b0001 << w_prioIdx;
                  r_state <= PULSO;
               end
            end
            PULSO: begin
               r_repCnt <= '0;
               r_state  <= ESPERA;
            end
            ESPERA: begin
               if (!w_ownerHeld) begin
                  r_state <= SOLTAR;
               end else if ((r_repCnt == REP_DELAY_PRE) && REP_EN[r_owner]) begin
                  r_en     <= w_ownerMask;
                  r_repCnt <= '0;
                  r_state  <= REPITE;
               end else if (r_repCnt != REP_DELAY_LAST) begin
                  r_repCnt <= r_repCnt + CNT_ONE;
               end
            end
            REPITE: begin
               if (!w_ownerHeld) begin
                  r_state <= SOLTAR;
               end else if (r_repCnt == REP_RATE_LAST) begin
                  r_en     <= w_ownerMask;
                  r_repCnt <= '0;
               end else begin
                  r_repCnt <= r_repCnt + CNT_ONE;
               end
            end
            SOLTAR: begin
               if (r_estado == 4'b0000) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign enUP       = r_en[0];
   assign enDOWN     = r_en[1];
   assign enRIGHT    = r_en[2];
   assign enLEFT     = r_en[3];
   assign btn_estado = r_estado;

endmodule
